// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch sequencer: PC, imem handshake, 2-entry fetch buffer, redirects
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exception
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT} state_t;

  state_t      state;
  logic [31:0] pc, pc_nx, target;
  logic [1:0]  count;
  logic        discard;
  logic [31:0] e1_instr, e1_pc, e1_pc4;
  logic        redirect, push, pop, hold;

  assign redirect = exception | jump | branch_taken;
  assign if_valid = (count != 2'd0);

  always_comb begin
    if (exception)  target = EXC_VECTOR;
    else if (jump)  target = jump_target;
    else            target = branch_target;
    target[1:0] = 2'b00;
  end

  always_comb begin
    imem_req = 1'b0;
    case (state)
      FETCH:   imem_req = (count < 2'd2) && !redirect;
      WAIT:    imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // A return that arrives after (or with) a redirect is dropped, not pushed.
  assign push = imem_req && imem_ready && !redirect && !(state == WAIT && discard);
  assign pop  = if_valid && !stall && !redirect;

  // Memory address must stay put while a request is outstanding.
  assign hold = (state == FETCH && imem_req && !imem_ready) || (state == WAIT && !imem_ready);

  always_comb begin
    pc_nx = pc;
    if (redirect)  pc_nx = target;
    else if (push) pc_nx = pc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
      count     <= 2'd0;
      discard   <= 1'b0;
      if_instr  <= 32'd0;
      if_pc     <= 32'd0;
      if_pc4    <= 32'd0;
      e1_instr  <= 32'd0;
      e1_pc     <= 32'd0;
      e1_pc4    <= 32'd0;
    end else begin
      pc <= pc_nx;
      if (!hold) imem_addr <= pc_nx;

      case (state)
        IDLE:  state <= FETCH;
        FETCH: if (imem_req && !imem_ready) state <= WAIT;
        WAIT: begin
          if (imem_ready) begin
            state   <= FETCH;
            discard <= 1'b0;
          end else if (redirect) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (redirect) begin
        count <= 2'd0;
      end else if (push && pop) begin
        if (count == 2'd1) begin
          if_instr <= imem_rdata;
          if_pc    <= pc;
          if_pc4   <= pc + 32'd4;
        end else begin
          if_instr <= e1_instr;
          if_pc    <= e1_pc;
          if_pc4   <= e1_pc4;
          e1_instr <= imem_rdata;
          e1_pc    <= pc;
          e1_pc4   <= pc + 32'd4;
        end
      end else if (push) begin
        if (count == 2'd0) begin
          if_instr <= imem_rdata;
          if_pc    <= pc;
          if_pc4   <= pc + 32'd4;
        end else begin
          e1_instr <= imem_rdata;
          e1_pc    <= pc;
          e1_pc4   <= pc + 32'd4;
        end
        count <= count + 2'd1;
      end else if (pop) begin
        if_instr <= e1_instr;
        if_pc    <= e1_pc;
        if_pc4   <= e1_pc4;
        count    <= count - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed and randomized bench for fetch_sequencer against an instruction-stream model
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] EXC    = 32'h0000_0080;

  logic        clk, rst_n;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, if_pc4;
  logic        stall, branch_taken, jump, exception;
  logic [31:0] branch_target, jump_target;

  logic        w_req, w_ready, w_valid;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4;

  int checks = 0;
  int errors = 0;
  bit want_ready;

  int          occ;
  logic [31:0] fetch_pc, exp_pop, held;
  bit          outstanding, drop, idle;

  fetch_sequencer #(.RESET_PC(RST_PC), .EXC_VECTOR(EXC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .exception(exception)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .EXC_VECTOR(EXC)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_ready), .imem_rdata(w_rdata),
    .if_valid(w_valid), .if_instr(w_instr), .if_pc(w_pc), .if_pc4(w_pc4),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .exception(exception)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: memory answers, model predicts the edge, then advance to the next negedge.
  task automatic cyc();
    logic        redir, m_pop;
    logic [31:0] tgt;
    #1;
    imem_ready = imem_req && want_ready;
    imem_rdata = imem_ready ? memfn(imem_addr) : $urandom;
    w_ready    = w_req && want_ready;
    w_rdata    = memfn(w_addr);
    #1;
    redir = exception | jump | branch_taken;
    tgt   = exception ? EXC : (jump ? jump_target : branch_target);
    tgt   = tgt & 32'hFFFF_FFFC;
    chk("if_valid", {31'd0, if_valid}, {31'd0, occ != 0});
    if (idle) begin
      chk("req_idle", {31'd0, imem_req}, 32'd0);
    end else if (outstanding) begin
      chk("req_hold", {31'd0, imem_req}, 32'd1);
      chk("addr_hold", imem_addr, held);
    end else begin
      chk("req", {31'd0, imem_req}, {31'd0, (occ < 2) && !redir});
      chk("addr", imem_addr, fetch_pc);
    end
    m_pop = (occ != 0) && !stall && !redir;
    if (m_pop) begin
      chk("pop_pc", if_pc, exp_pop);
      chk("pop_instr", if_instr, memfn(exp_pop));
      chk("pop_pc4", if_pc4, exp_pop + 32'd4);
    end
    if (redir) begin
      occ = 0;
      exp_pop = tgt;
      fetch_pc = tgt;
      if (outstanding) begin
        if (imem_ready) begin
          outstanding = 0;
          drop = 0;
        end else begin
          drop = 1;
        end
      end
    end else begin
      if (imem_ready) begin
        if (drop) drop = 0;
        else begin
          occ++;
          fetch_pc = fetch_pc + 32'd4;
        end
        outstanding = 0;
      end else if (imem_req && !outstanding) begin
        outstanding = 1;
        held = fetch_pc;
      end
      if (m_pop) begin
        occ--;
        exp_pop = exp_pop + 32'd4;
      end
    end
    idle = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; exception = 1'b0;
    branch_target = 32'd0; jump_target = 32'd0; imem_ready = 1'b0; imem_rdata = 32'd0;
    w_ready = 1'b0; w_rdata = 32'd0; want_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pc4", if_pc4, 32'd0);

    rst_n = 1'b1;
    occ = 0; fetch_pc = RST_PC; exp_pop = RST_PC; held = RST_PC;
    outstanding = 0; drop = 0; idle = 1;

    want_ready = 1'b1;
    cyc();

    for (int i = 0; i < 4; i++) begin
      chk("stream_addr", imem_addr, RST_PC + 32'(4 * i));
      if (i > 0) begin
        chk("stream_if_pc", if_pc, RST_PC + 32'(4 * (i - 1)));
        chk("stream_if_pc4", if_pc4, RST_PC + 32'(4 * i));
      end
      if (i == 0) chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      if (i == 1) begin
        chk("wrap_addr1", w_addr, 32'h0000_0000);
        chk("wrap_valid", {31'd0, w_valid}, 32'd1);
        chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", w_pc4, 32'h0000_0000);
        chk("wrap_instr", w_instr, memfn(32'hFFFF_FFFC));
      end
      cyc();
    end

    stall = 1'b1;
    repeat (6) cyc();
    chk("bp_req", {31'd0, imem_req}, 32'd0);
    chk("bp_valid", {31'd0, if_valid}, 32'd1);
    chk("bp_head", if_pc, 32'h0040_000C);
    stall = 1'b0;
    cyc();
    chk("bp_resume_addr", imem_addr, 32'h0040_0014);
    chk("bp_second", if_pc, 32'h0040_0010);

    want_ready = 1'b0;
    cyc();
    branch_taken = 1'b1; branch_target = 32'h0040_0103;
    cyc();
    branch_taken = 1'b0;
    cyc();
    cyc();
    want_ready = 1'b1;
    cyc();
    chk("wait_redir_addr", imem_addr, 32'h0040_0100);
    chk("wait_redir_valid", {31'd0, if_valid}, 32'd0);

    exception = 1'b1; jump = 1'b1; jump_target = 32'h0000_1000;
    branch_taken = 1'b1; branch_target = 32'h0000_2000;
    cyc();
    exception = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    chk("prio_addr", imem_addr, EXC);
    chk("prio_valid", {31'd0, if_valid}, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      stall         = ($urandom_range(99) < 30);
      exception     = ($urandom_range(99) < 3);
      jump          = ($urandom_range(99) < 4);
      branch_taken  = ($urandom_range(99) < 6);
      jump_target   = $urandom;
      branch_target = $urandom;
      want_ready    = ($urandom_range(99) < 60);
      cyc();
    end
    stall = 1'b0; exception = 1'b0; jump = 1'b0; branch_taken = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
